pipelined_memory: RTL and testbench

PIPELINED_MEMORY -- requirements
Module: pipelined_memory

---
 rtl/pipelined_memory_if.sv | 56 +++++
 rtl/pipelined_memory.sv | 150 +++++++++++++++
 tb/tb_pipelined_memory.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_memory_if.sv
// Shared types and the fetch/data bus bundle for pipelined_memory.
// The master drives requests; the slave (the memory) returns ready and responses.
package pipelined_memory_pkg;

  typedef enum logic [1:0] {
    TSIZE_WORD     = 2'b00,
    TSIZE_HALFWORD = 2'b01,
    TSIZE_BYTE     = 2'b10
  } tsize_e;

  // One response pipeline stage; data and err are zero whenever valid is zero.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } rsp_t;

endpackage

interface pipelined_memory_if;
  import pipelined_memory_pkg::*;

  // Fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  // Data port
  logic        d_req;
  logic        d_we;
  tsize_e      d_tsize;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  modport master (
    output i_req, i_addr,
    input  i_ready, i_rvalid, i_rdata, i_err,
    output d_req, d_we, d_tsize, d_addr, d_wdata,
    input  d_ready, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  i_req, i_addr,
    output i_ready, i_rvalid, i_rdata, i_err,
    input  d_req, d_we, d_tsize, d_addr, d_wdata,
    output d_ready, d_rvalid, d_rdata, d_err
  );

endinterface

// File: rtl/pipelined_memory.sv
// Dual-port (fetch + data) big-endian byte memory with a fixed LATENCY-cycle
// response pipeline per port; writes commit on the accept edge.
module pipelined_memory
  import pipelined_memory_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_memory_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0] r_mem [DEPTH];

  function automatic logic [31:0] read_word(input logic [AW-1:0] a);
    return {r_mem[a], r_mem[a + AW'(1)], r_mem[a + AW'(2)], r_mem[a + AW'(3)]};
  endfunction

  // 33-bit sum so addresses near 2^32 cannot wrap back into range.
  function automatic logic range_err(input logic [31:0] addr, input logic [2:0] nbytes);
    return ({1'b0, addr} + 33'(nbytes) - 33'd1) >= 33'(DEPTH);
  endfunction

  assign bus.i_ready = rst_n;
  assign bus.d_ready = rst_n;

  // ---------------- Fetch port ----------------
  logic w_i_acc;
  logic w_i_err;
  rsp_t w_i_rsp;

  assign w_i_acc = bus.i_req & rst_n;
  assign w_i_err = (bus.i_addr[1:0] != 2'b00) | range_err(bus.i_addr, 3'd4);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_i_rsp = '0;
    if (w_i_acc) begin
      w_i_rsp.valid = 1'b1;
      w_i_rsp.err   = w_i_err;
      if (!w_i_err) w_i_rsp.data = read_word(bus.i_addr[AW-1:0]);
    end
  end

  // ---------------- Data port ----------------
  logic          w_d_acc;
  logic          w_d_bad;
  logic          w_d_err;
  logic [2:0]    w_d_nbytes;
  logic [AW-1:0] w_d_a0;
  logic [AW-1:0] w_d_a1;
  logic [AW-1:0] w_d_a2;
  logic [AW-1:0] w_d_a3;
  logic [31:0]   w_d_rdata;
  logic          w_d_wr_en;
  rsp_t          w_d_rsp;

  assign w_d_acc = bus.d_req & rst_n;
  assign w_d_a0  = bus.d_addr[AW-1:0];
  assign w_d_a1  = w_d_a0 + AW'(1);
  assign w_d_a2  = w_d_a0 + AW'(2);
  assign w_d_a3  = w_d_a0 + AW'(3);

  always_comb begin
    w_d_nbytes = 3'd1;
    w_d_bad    = 1'b0;
    w_d_rdata  = '0;
    case (bus.d_tsize)
      TSIZE_WORD: begin
        w_d_nbytes = 3'd4;
        w_d_bad    = (bus.d_addr[1:0] != 2'b00);
        w_d_rdata  = {r_mem[w_d_a0], r_mem[w_d_a1], r_mem[w_d_a2], r_mem[w_d_a3]};
      end
      TSIZE_HALFWORD: begin
        w_d_nbytes = 3'd2;
        w_d_bad    = bus.d_addr[0];
        w_d_rdata  = {16'h0, r_mem[w_d_a0], r_mem[w_d_a1]};
      end
      TSIZE_BYTE: begin
        w_d_nbytes = 3'd1;
        w_d_rdata  = {24'h0, r_mem[w_d_a0]};
      end
      default: w_d_bad = 1'b1;
    endcase
  end

  assign w_d_err   = w_d_bad | range_err(bus.d_addr, w_d_nbytes);
  assign w_d_wr_en = w_d_acc & bus.d_we & ~w_d_err;

  always_comb begin
    w_d_rsp = '0;
    if (w_d_acc) begin
      w_d_rsp.valid = 1'b1;
      w_d_rsp.err   = w_d_err;
      if (!w_d_err && !bus.d_we) w_d_rsp.data = w_d_rdata;
    end
  end

  // NOTE: the byte array has no reset; its contents must survive rst_n.
  always_ff @(posedge clk) begin
    if (w_d_wr_en) begin
      case (bus.d_tsize)
        TSIZE_WORD: begin
          r_mem[w_d_a0] <= bus.d_wdata[31:24];
          r_mem[w_d_a1] <= bus.d_wdata[23:16];
          r_mem[w_d_a2] <= bus.d_wdata[15:8];
          r_mem[w_d_a3] <= bus.d_wdata[7:0];
        end
        TSIZE_HALFWORD: begin
          r_mem[w_d_a0] <= bus.d_wdata[15:8];
          r_mem[w_d_a1] <= bus.d_wdata[7:0];
        end
        TSIZE_BYTE: r_mem[w_d_a0] <= bus.d_wdata[7:0];
        default: ;
      endcase
    end
  end

  // ---------------- Response pipelines ----------------
  rsp_t r_i_pipe [LATENCY];
  rsp_t r_d_pipe [LATENCY];

  // NOTE: non-blocking assignments let every stage shift from its pre-edge neighbour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_i_pipe[s] <= '0;
        r_d_pipe[s] <= '0;
      end
    end else begin
      r_i_pipe[0] <= w_i_rsp;
      r_d_pipe[0] <= w_d_rsp;
      for (int s = 1; s < LATENCY; s++) begin
        r_i_pipe[s] <= r_i_pipe[s-1];
        r_d_pipe[s] <= r_d_pipe[s-1];
      end
    end
  end

  assign bus.i_rvalid = r_i_pipe[LATENCY-1].valid;
  assign bus.i_err    = r_i_pipe[LATENCY-1].err;
  assign bus.i_rdata  = r_i_pipe[LATENCY-1].data;
  assign bus.d_rvalid = r_d_pipe[LATENCY-1].valid;
  assign bus.d_err    = r_d_pipe[LATENCY-1].err;
  assign bus.d_rdata  = r_d_pipe[LATENCY-1].data;

endmodule

// File: tb/tb_pipelined_memory.sv
// Directed, table-driven bench for pipelined_memory at LATENCY=2, DEPTH=4096,
// plus hand-written sequences for back-to-back traffic and mid-run reset.
module tb_pipelined_memory;
  import pipelined_memory_pkg::*;

  localparam logic [1:0] W = 2'd0;
  localparam logic [1:0] H = 2'd1;
  localparam logic [1:0] B = 2'd2;
  localparam logic [1:0] X = 2'd3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pipelined_memory_if bus ();

  pipelined_memory #(.DEPTH(4096), .LATENCY(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        d_req;
    logic        d_we;
    logic [1:0]  tsize;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] exp_d;
    logic        exp_d_err;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] exp_i;
    logic        exp_i_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic d_req, input logic d_we, input logic [1:0] tsize,
                              input logic [31:0] d_addr, input logic [31:0] d_wdata,
                              input logic [31:0] exp_d, input logic exp_d_err,
                              input logic i_req, input logic [31:0] i_addr,
                              input logic [31:0] exp_i, input logic exp_i_err);
    vec_t v;
    v.d_req = d_req; v.d_we = d_we; v.tsize = tsize; v.d_addr = d_addr; v.d_wdata = d_wdata;
    v.exp_d = exp_d; v.exp_d_err = exp_d_err;
    v.i_req = i_req; v.i_addr = i_addr; v.exp_i = exp_i; v.exp_i_err = exp_i_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_tsize = TSIZE_WORD;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic drive_d(input logic we, input logic [1:0] tsize,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_tsize = tsize_e'(tsize);
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
  endtask

  task automatic check_d(input string tag, input logic v, input logic e, input logic [31:0] d);
    check({tag, " d_rvalid"}, 32'(bus.d_rvalid), 32'(v));
    check({tag, " d_err"},    32'(bus.d_err),    32'(e));
    check({tag, " d_rdata"},  bus.d_rdata,       d);
  endtask

  task automatic check_i(input string tag, input logic v, input logic e, input logic [31:0] d);
    check({tag, " i_rvalid"}, 32'(bus.i_rvalid), 32'(v));
    check({tag, " i_err"},    32'(bus.i_err),    32'(e));
    check({tag, " i_rdata"},  bus.i_rdata,       d);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();

    //           dreq we tsz addr       wdata         exp_d         derr ireq iaddr      exp_i         ierr
    vecs.push_back(mk(1, 1, W, 32'h010, 32'hDEADBEEF, 32'h0,        0,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 0, B, 32'h011, 32'h0,        32'h000000AD, 0,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 1, W, 32'h020, 32'h11223344, 32'h0,        0,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 1, H, 32'h022, 32'h00001234, 32'h0,        0,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 0, W, 32'h020, 32'h0,        32'h11221234, 0,   1, 32'h010,   32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 0, W, 32'h013, 32'h0,        32'h0,        1,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 1, H, 32'h021, 32'h0000BEEF, 32'h0,        1,   1, 32'h006,   32'h0,        1));
    vecs.push_back(mk(1, 0, W, 32'h020, 32'h0,        32'h11221234, 0,   1, 32'h020,   32'h11221234, 0));
    vecs.push_back(mk(1, 1, W, 32'hFFC, 32'hCAFEF00D, 32'h0,        0,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 0, W, 32'hFFC, 32'h0,        32'hCAFEF00D, 0,   1, 32'hFFC,   32'hCAFEF00D, 0));
    vecs.push_back(mk(1, 0, W, 32'h1000,32'h0,        32'h0,        1,   1, 32'h1000,  32'h0,        1));
    vecs.push_back(mk(1, 1, B, 32'hFFF, 32'h00000077, 32'h0,        0,   1, 32'hFFE,   32'h0,        1));
    vecs.push_back(mk(1, 0, H, 32'hFFF, 32'h0,        32'h0,        1,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 0, B, 32'hFFF, 32'h0,        32'h00000077, 0,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 0, H, 32'hFFE, 32'h0,        32'h0000F077, 0,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 1, B, 32'h1000,32'h000000AA, 32'h0,        1,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 0, X, 32'h010, 32'h0,        32'h0,        1,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 1, X, 32'h010, 32'h55555555, 32'h0,        1,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 0, W, 32'h010, 32'h0,        32'hDEADBEEF, 0,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 0, H, 32'h012, 32'h0,        32'h0000BEEF, 0,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 1, W, 32'h040, 32'h00000000, 32'h0,        0,   0, 32'h0,     32'h0,        0));
    vecs.push_back(mk(1, 1, W, 32'h040, 32'hA5A5A5A5, 32'h0,        0,   1, 32'h040,   32'h0,        0));
    vecs.push_back(mk(0, 0, W, 32'h0,   32'h0,        32'h0,        0,   1, 32'h040,   32'hA5A5A5A5, 0));

    // Reset: ready low, pipeline cleared.
    rst_n = 1'b0;
    step();
    step();
    check("rst i_ready", 32'(bus.i_ready), 32'd0);
    check("rst d_ready", 32'(bus.d_ready), 32'd0);
    check_d("rst", 1'b0, 1'b0, 32'h0);
    check_i("rst", 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    #1;
    check("post-rst i_ready", 32'(bus.i_ready), 32'd1);
    check("post-rst d_ready", 32'(bus.d_ready), 32'd1);

    // Table: one request pair every other cycle; response only at +LATENCY.
    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      v = vecs[k];
      if (v.d_req) drive_d(v.d_we, v.tsize, v.d_addr, v.d_wdata);
      bus.i_req  = v.i_req;
      bus.i_addr = v.i_addr;
      step();
      idle();
      check_d($sformatf("vec%0d +1", k), 1'b0, 1'b0, 32'h0);
      check_i($sformatf("vec%0d +1", k), 1'b0, 1'b0, 32'h0);
      step();
      check_d($sformatf("vec%0d +2", k), v.d_req, v.d_req & v.exp_d_err, v.d_req ? v.exp_d : 32'h0);
      check_i($sformatf("vec%0d +2", k), v.i_req, v.i_req & v.exp_i_err, v.i_req ? v.exp_i : 32'h0);
    end

    // Back-to-back: write then read the next cycle, with a parallel fetch.
    drive_d(1'b1, W, 32'h050, 32'h0BADF00D);
    step();
    check_d("b2b e0", 1'b0, 1'b0, 32'h0);
    drive_d(1'b0, W, 32'h050, 32'h0);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h040;
    step();
    idle();
    check_d("b2b wr rsp", 1'b1, 1'b0, 32'h0);
    check_i("b2b e1", 1'b0, 1'b0, 32'h0);
    step();
    check_d("b2b rd rsp", 1'b1, 1'b0, 32'h0BADF00D);
    check_i("b2b fetch", 1'b1, 1'b0, 32'hA5A5A5A5);
    step();
    check_d("b2b tail", 1'b0, 1'b0, 32'h0);
    check_i("b2b tail", 1'b0, 1'b0, 32'h0);

    // Mid-run reset: four back-to-back data requests, reset after the 2nd accept.
    drive_d(1'b0, W, 32'h010, 32'h0);
    step();
    drive_d(1'b0, W, 32'h050, 32'h0);
    step();
    check_d("mid r1", 1'b1, 1'b0, 32'hDEADBEEF);
    rst_n = 1'b0;
    drive_d(1'b1, W, 32'h010, 32'hFFFFFFFF);
    #1;
    check("mid rst d_ready", 32'(bus.d_ready), 32'd0);
    check("mid rst i_ready", 32'(bus.i_ready), 32'd0);
    step();
    check_d("mid after rst", 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    drive_d(1'b0, W, 32'h010, 32'h0);
    #1;
    check("mid post d_ready", 32'(bus.d_ready), 32'd1);
    step();
    idle();
    check_d("mid ignored wr", 1'b0, 1'b0, 32'h0);
    step();
    check_d("mid r4", 1'b1, 1'b0, 32'hDEADBEEF);
    step();
    check_d("mid tail", 1'b0, 1'b0, 32'h0);

    // Memory survives reset.
    drive_d(1'b0, W, 32'hFFC, 32'h0);
    step();
    idle();
    step();
    check_d("persist", 1'b1, 1'b0, 32'hCAFEF077);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
